// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / instruction-fetch stage.
//   - bselect encodings driven by the opcode decoder
//   - fetch FSM state encodings
//   - instruction width and field positions (opcode, branch offset)
package pc_fetch_unit_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int OPCODE_MSB  = 31;
  localparam int OPCODE_LSB  = 24;
  localparam int OFFSET_MSB  = 23;
  localparam int OFFSET_LSB  = 16;
  localparam int OFFSET_W    = OFFSET_MSB - OFFSET_LSB + 1;

  typedef enum logic [1:0] {
    BSEL_SEQ = 2'b00,
    BSEL_J   = 2'b01,
    BSEL_BEQ = 2'b10,
    BSEL_BNE = 2'b11
  } bsel_e;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_e;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC resolver.
//   pc      : current program counter
//   offset  : signed branch offset in instructions (instr[23:16])
//   bselect : 00 seq, 01 jump, 10 beq, 11 bne
//   zero    : ALU zero flag
//   next_pc : resolved next PC, modulo 2^PC_WIDTH
module next_pc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [1:0]          bselect,
  input  logic                zero,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] offset_bytes;
  logic [PC_WIDTH-1:0] target;
  logic                take_target;

  // Offset counts instructions, so sign-extend and scale by 4 bytes.
  assign offset_bytes = {{(PC_WIDTH-OFFSET_W-2){offset[OFFSET_W-1]}}, offset, 2'b00};
  assign pc_plus4     = pc + PC_WIDTH'(4);
  assign target       = pc_plus4 + offset_bytes;

  always_comb begin
    take_target = 1'b0;
    case (bselect)
      BSEL_SEQ: take_target = 1'b0;
      BSEL_J:   take_target = 1'b1;
      BSEL_BEQ: take_target = zero;
      BSEL_BNE: take_target = ~zero;
      default:  take_target = 1'b0;
    endcase
  end

  assign next_pc = take_target ? target : pc_plus4;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage feeding the opcode decoder.
// Fetches one instruction per FETCH/EXEC pair using a busywait handshake,
// presents it for one execute window, then resolves the next PC.
//   CLK, RESET         : clock, async active-high reset
//   imem_read/addr     : fetch request and address (addr == pc)
//   imem_busywait      : memory not ready
//   instruction_in     : fetched word
//   instr_out/valid    : latched instruction, valid during EXEC
//   bselect, zero      : branch select and ALU zero, sampled in EXEC only
//   stall              : downstream busy, freezes EXEC
//   pc                 : current program counter
//
// state | meaning
// FETCH | request instruction at pc, wait for busywait low
// EXEC  | instruction presented to decode; update pc when not stalled
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  output logic                   imem_read,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_busywait,
  input  logic [INSTR_WIDTH-1:0] instruction_in,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  input  logic [1:0]             bselect,
  input  logic                   zero,
  input  logic                   stall,
  output logic [PC_WIDTH-1:0]    pc
);

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    next_pc;

  next_pc_calc #(.PC_WIDTH(PC_WIDTH)) u_next_pc_calc (
    .pc      (pc_q),
    .offset  (instr_q[OFFSET_MSB:OFFSET_LSB]),
    .bselect (bselect),
    .zero    (zero),
    .next_pc (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      FETCH: begin
        if (!imem_busywait) begin
          instr_d = instruction_in;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Gate the request with RESET so memory sees no fetch while held in reset.
  assign imem_read   = !RESET && (state_q == FETCH);
  assign instr_valid = (state_q == EXEC);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_out   = instr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        CLK;
  logic        RESET;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic        imem_busywait;
  logic [31:0] instruction_in;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [1:0]  bselect;
  logic        zero;
  logic        stall;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .imem_read      (imem_read),
    .imem_addr      (imem_addr),
    .imem_busywait  (imem_busywait),
    .instruction_in (instruction_in),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .bselect        (bselect),
    .zero           (zero),
    .stall          (stall),
    .pc             (pc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // Runs one zero-wait instruction: FETCH edge, then EXEC edge with the given
  // bselect/zero. bselect/zero are X during FETCH to show they are ignored there.
  task automatic run_instr(input logic [31:0] instr, input logic [1:0] bsel, input logic z,
                           output logic ex_valid, output logic [31:0] ex_instr,
                           output logic [31:0] ex_pc, output logic fe_valid,
                           output logic [31:0] pc_after);
    instruction_in = instr;
    imem_busywait  = 1'b0;
    stall          = 1'b0;
    bselect        = 2'bxx;
    zero           = 1'bx;
    @(posedge CLK); @(negedge CLK);
    ex_valid = instr_valid;
    ex_instr = instr_out;
    ex_pc    = pc;
    bselect  = bsel;
    zero     = z;
    @(posedge CLK); @(negedge CLK);
    fe_valid = instr_valid;
    pc_after = pc;
    bselect  = 2'bxx;
    zero     = 1'bx;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    #2;
    checks++;
    if (pc !== 32'h0 || instr_valid !== 1'b0 || instr_out !== 32'h0 || imem_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h valid=%b instr=%h read=%b, required pc=0 valid=0 instr=0 read=0",
               pc, instr_valid, instr_out, imem_read);
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    checks++;
    if (imem_read !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: read=%b addr=%h, required read=1 addr=0", imem_read, imem_addr);
    end
  endtask

  task automatic test_reset();
    imem_busywait  = 1'b0;
    instruction_in = 32'hDEAD_BEEF;
    stall          = 1'b0;
    bselect        = 2'b00;
    zero           = 1'b0;
    apply_reset();
  endtask

  task automatic test_sequential();
    logic v, fv;
    logic [31:0] ins, epc, pa;
    logic [31:0] words [4] = '{32'h1100_0001, 32'h2201_0002, 32'hFF7F_0003, 32'h0480_0004};
    for (int i = 0; i < 4; i++) begin
      run_instr(words[i], 2'b00, 1'b1, v, ins, epc, fv, pa);
      checks++;
      if (v !== 1'b1 || ins !== words[i] || epc !== 32'(i * 4)) begin
        errors++;
        $display("FAIL seq_exec%0d: valid=%b instr=%h pc=%h, required valid=1 instr=%h pc=%h",
                 i, v, ins, epc, words[i], 32'(i * 4));
      end
      checks++;
      if (fv !== 1'b0 || pa !== 32'(i * 4 + 4)) begin
        errors++;
        $display("FAIL seq_next%0d: valid=%b pc=%h, required valid=0 pc=%h", i, fv, pa, 32'(i * 4 + 4));
      end
    end
  endtask

  task automatic test_jump_neg();
    logic v, fv;
    logic [31:0] ins, epc, pa;
    run_instr(32'h05FE_0000, 2'b01, 1'b0, v, ins, epc, fv, pa);
    checks++;
    if (epc !== 32'h10 || pa !== 32'h0C) begin
      errors++;
      $display("FAIL jump_neg: from=%h to=%h, required from=00000010 to=0000000c", epc, pa);
    end
    run_instr(32'h0504_0000, 2'b01, 1'b0, v, ins, epc, fv, pa);
    checks++;
    if (pa !== 32'h20) begin
      errors++;
      $display("FAIL jump_pos: pc=%h, required 00000020", pa);
    end
  endtask

  task automatic test_branches();
    logic v, fv;
    logic [31:0] ins, epc, pa;
    logic [1:0]  bs   [4] = '{2'b10, 2'b10, 2'b11, 2'b11};
    logic        zs   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp  [4] = '{32'h30, 32'h24, 32'h30, 32'h24};
    logic [7:0]  back [4] = '{8'hFB, 8'hFE, 8'hFB, 8'hFE};
    for (int i = 0; i < 4; i++) begin
      run_instr(32'h0A03_0000, bs[i], zs[i], v, ins, epc, fv, pa);
      checks++;
      if (epc !== 32'h20 || pa !== exp[i]) begin
        errors++;
        $display("FAIL branch%0d bsel=%b zero=%b: from=%h to=%h, required from=00000020 to=%h",
                 i, bs[i], zs[i], epc, pa, exp[i]);
      end
      run_instr({8'h05, back[i], 16'h0}, 2'b01, 1'b0, v, ins, epc, fv, pa);
      checks++;
      if (pa !== 32'h20) begin
        errors++;
        $display("FAIL branch_return%0d: pc=%h, required 00000020", i, pa);
      end
    end
  endtask

  task automatic test_busywait_stall();
    instruction_in = 32'h0BAD_0000;
    imem_busywait  = 1'b1;
    stall          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); @(negedge CLK);
      checks++;
      if (imem_read !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'h20) begin
        errors++;
        $display("FAIL busywait%0d: read=%b valid=%b pc=%h, required read=1 valid=0 pc=00000020",
                 i, imem_read, instr_valid, pc);
      end
    end
    imem_busywait  = 1'b0;
    instruction_in = 32'h0C00_0000;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== 32'h0C00_0000 || imem_read !== 1'b0) begin
      errors++;
      $display("FAIL busy_capture: valid=%b instr=%h read=%b, required valid=1 instr=0c000000 read=0",
               instr_valid, instr_out, imem_read);
    end
    bselect = 2'b00;
    zero    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); @(negedge CLK);
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'h20) begin
        errors++;
        $display("FAIL stall%0d: valid=%b pc=%h, required valid=1 pc=00000020", i, instr_valid, pc);
      end
    end
    stall = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (instr_valid !== 1'b0 || pc !== 32'h24) begin
      errors++;
      $display("FAIL stall_release: valid=%b pc=%h, required valid=0 pc=00000024", instr_valid, pc);
    end
  endtask

  task automatic test_async_reset();
    logic v, fv;
    logic [31:0] ins, epc, pa;
    run_instr(32'h0506_0000, 2'b01, 1'b0, v, ins, epc, fv, pa);
    checks++;
    if (pa !== 32'h40) begin
      errors++;
      $display("FAIL goto_40: pc=%h, required 00000040", pa);
    end
    instruction_in = 32'h0510_0000;
    imem_busywait  = 1'b0;
    @(posedge CLK); @(negedge CLK);
    bselect = 2'b01;
    zero    = 1'b0;
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h0 || instr_valid !== 1'b0 || instr_out !== 32'h0 || imem_read !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pc=%h valid=%b instr=%h read=%b, required pc=0 valid=0 instr=0 read=0",
               pc, instr_valid, instr_out, imem_read);
    end
    @(negedge CLK);
    RESET = 1'b0;
    run_instr(32'h0000_0000, 2'b00, 1'b0, v, ins, epc, fv, pa);
    checks++;
    if (epc !== 32'h0 || pa !== 32'h4) begin
      errors++;
      $display("FAIL post_reset_fetch: from=%h to=%h, required from=0 to=4", epc, pa);
    end
  endtask

  task automatic test_wrap();
    logic v, fv;
    logic [31:0] ins, epc, pa;
    apply_reset();
    run_instr(32'h0580_0000, 2'b01, 1'b0, v, ins, epc, fv, pa);
    checks++;
    if (pa !== 32'hFFFF_FE04 || imem_addr !== 32'hFFFF_FE04) begin
      errors++;
      $display("FAIL wrap_neg128: pc=%h addr=%h, required fffffe04", pa, imem_addr);
    end
    run_instr(32'h057D_0000, 2'b01, 1'b0, v, ins, epc, fv, pa);
    checks++;
    if (pa !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL goto_top: pc=%h, required fffffffc", pa);
    end
    run_instr(32'h0000_0000, 2'b00, 1'b1, v, ins, epc, fv, pa);
    checks++;
    if (pa !== 32'h0) begin
      errors++;
      $display("FAIL wrap_seq: pc=%h, required 00000000", pa);
    end
  endtask

  initial begin
    RESET          = 1'b1;
    imem_busywait  = 1'b0;
    instruction_in = 32'h0;
    bselect        = 2'b00;
    zero           = 1'b0;
    stall          = 1'b0;
    test_reset();
    test_sequential();
    test_jump_neg();
    test_branches();
    test_busywait_stall();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
